// File: rtl/execute_unit_md.sv
// RV32IM execute stage: single-cycle ALU/branch judge, fixed-latency multiply and
// iterative restoring divide, with valid/ready handshakes toward ID/EX and MEM.
module execute_unit_md #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int M_EXT   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic            alu_op1_src,
    input  logic [XLEN-1:0] reg1_rd,
    input  logic [XLEN-1:0] pc,
    input  logic            alu_op2_src,
    input  logic [XLEN-1:0] reg2_rd,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            jump_flag,
    output logic            illegal_op,
    output logic            busy
);
    localparam int SH_W    = $clog2(XLEN);
    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state, next_state, start_state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op1, op2, dec_result, div_special_result;
    logic             dec_jump, dec_illegal, dec_mul, dec_div, div_special;
    logic             accept, div_signed, a_neg, b_neg, unused_fields;
    logic [XLEN-1:0]  opa_p1, opb_p1, quo_p1, rem_p1, dvs_p1;
    logic [2:0]       f3_p1;
    logic             neg_q_p1, neg_r_p1;
    logic [XLEN:0]    rem_sh, trial;
    logic [XLEN-1:0]  rem_nx, quo_nx, div_final;

    function automatic logic [XLEN-1:0] alu_fn(input logic [2:0] f3, input logic alt,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        logic [SH_W-1:0]        sh;
        sa = a;
        sb = b;
        sh = b[SH_W-1:0];
        case (f3)
            3'b000:  alu_fn = alt ? a - b : a + b;
            3'b001:  alu_fn = a << sh;
            3'b010:  alu_fn = {{(XLEN-1){1'b0}}, sa < sb};
            3'b011:  alu_fn = {{(XLEN-1){1'b0}}, a < b};
            3'b100:  alu_fn = a ^ b;
            3'b101: begin
                if (alt) alu_fn = sa >>> sh;
                else     alu_fn = a >> sh;
            end
            3'b110:  alu_fn = a | b;
            default: alu_fn = a & b;
        endcase
    endfunction

    function automatic logic branch_fn(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  branch_fn = (a == b);
            3'b001:  branch_fn = (a != b);
            3'b100:  branch_fn = (sa < sb);
            3'b101:  branch_fn = (sa >= sb);
            3'b110:  branch_fn = (a < b);
            3'b111:  branch_fn = (a >= b);
            default: branch_fn = 1'b0;
        endcase
    endfunction

    // Sign/zero extension to 2*XLEN yields correct high halves for all four variants.
    function automatic logic [XLEN-1:0] mul_fn(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ax, bx, prod;
        ax   = {{XLEN{a[XLEN-1] & (f3 == 3'b001 || f3 == 3'b010)}}, a};
        bx   = {{XLEN{b[XLEN-1] & (f3 == 3'b001)}}, b};
        prod = ax * bx;
        mul_fn = (f3 == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};
    assign op1           = alu_op1_src ? pc : reg1_rd;
    assign op2           = alu_op2_src ? imm : reg2_rd;

    always_comb begin
        dec_result  = '0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;
        dec_mul     = 1'b0;
        dec_div     = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000001) begin
                    if (M_EXT != 0) begin
                        dec_mul = !funct3[2];
                        dec_div = funct3[2];
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end else if (funct7 == 7'b0000000 ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_result = alu_fn(funct3, funct7[5], op1, op2);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0010011: begin
                if ((funct3 == 3'b001 && funct7 != 7'd0) ||
                    (funct3 == 3'b101 && funct7 != 7'd0 && funct7 != 7'b0100000))
                    dec_illegal = 1'b1;
                else
                    dec_result = alu_fn(funct3, funct3 == 3'b101 && funct7[5], op1, op2);
            end
            7'b0110111:                         dec_result = op2;
            7'b0010111, 7'b0000011, 7'b0100011: dec_result = op1 + op2;
            7'b1101111, 7'b1100111: begin
                dec_result = pc + XLEN'(4);
                dec_jump   = 1'b1;
            end
            7'b1100011: begin
                if (funct3[2:1] == 2'b01) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_result = op1 + op2;
                    dec_jump   = branch_fn(funct3, reg1_rd, reg2_rd);
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Zero divisor and min/-1 bypass the iteration entirely.
    assign div_signed = !funct3[0];
    assign a_neg      = div_signed & op1[XLEN-1];
    assign b_neg      = div_signed & op2[XLEN-1];

    always_comb begin
        div_special        = 1'b0;
        div_special_result = '0;
        if (op2 == '0) begin
            div_special        = 1'b1;
            div_special_result = funct3[1] ? op1 : '1;
        end else if (div_signed && op1 == MIN_NEG && op2 == '1) begin
            div_special        = 1'b1;
            div_special_result = funct3[1] ? '0 : MIN_NEG;
        end
    end

    always_comb begin
        start_state = S_DONE;
        if (dec_mul && MUL_LAT != 0)      start_state = S_MUL;
        else if (dec_div && !div_special) start_state = S_DIV;
    end

    assign in_ready  = !flush && (state == S_IDLE || (state == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL) || (state == S_DIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) next_state = start_state;
                S_DONE: begin
                    if (accept)         next_state = start_state;
                    else if (out_ready) next_state = S_IDLE;
                end
                S_MUL, S_DIV: if (cnt == CNT_W'(1)) next_state = S_DONE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (flush)
            cnt <= '0;
        else if (accept)
            cnt <= (start_state == S_MUL) ? CNT_W'(MUL_LAT) :
                   (start_state == S_DIV) ? CNT_W'(XLEN) : '0;
        else if (busy)
            cnt <= cnt - CNT_W'(1);
    end

    // Restoring step: shift in the next dividend bit, keep the subtraction if it did not borrow.
    always_comb begin
        rem_sh = {rem_p1, quo_p1[XLEN-1]};
        trial  = rem_sh - {1'b0, dvs_p1};
        quo_nx = {quo_p1[XLEN-2:0], !trial[XLEN]};
        rem_nx = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        if (f3_p1[1]) div_final = neg_r_p1 ? -rem_nx : rem_nx;
        else          div_final = neg_q_p1 ? -quo_nx : quo_nx;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opa_p1   <= op1;
            opb_p1   <= op2;
            f3_p1    <= funct3;
            quo_p1   <= a_neg ? -op1 : op1;
            dvs_p1   <= b_neg ? -op2 : op2;
            rem_p1   <= '0;
            neg_q_p1 <= a_neg ^ b_neg;
            neg_r_p1 <= a_neg;
        end else if (state == S_DIV) begin
            quo_p1 <= quo_nx;
            rem_p1 <= rem_nx;
        end
    end

    // Result registers change only on accept or multi-cycle completion, so S_DONE holds them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result <= '0;
            jump_flag  <= 1'b0;
            illegal_op <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                jump_flag  <= dec_jump;
                illegal_op <= dec_illegal;
                if (dec_mul && MUL_LAT == 0) alu_result <= mul_fn(funct3, op1, op2);
                else if (dec_div)            alu_result <= div_special_result;
                else                         alu_result <= dec_result;
            end else if (state == S_MUL && cnt == CNT_W'(1)) begin
                alu_result <= mul_fn(f3_p1, opa_p1, opb_p1);
            end else if (state == S_DIV && cnt == CNT_W'(1)) begin
                alu_result <= div_final;
            end
        end
    end
endmodule

// File: tb/tb_execute_unit_md.sv
// Directed bench for execute_unit_md: a vector table of single-cycle ops plus
// hand-written multiply/divide, stall, flush and reset sequences.
module tb_execute_unit_md;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPI   = 7'b0010011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] MD    = 7'b0000001;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, alu_op1_src, alu_op2_src;
    logic [31:0]     instruction;
    logic [XLEN-1:0] reg1_rd, pc, reg2_rd, imm, alu_result;
    logic            out_valid, out_ready, jump_flag, illegal_op, busy;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    execute_unit_md #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .M_EXT(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .alu_op1_src(alu_op1_src), .reg1_rd(reg1_rd), .pc(pc),
        .alu_op2_src(alu_op2_src), .reg2_rd(reg2_rd), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .alu_result(alu_result), .jump_flag(jump_flag),
        .illegal_op(illegal_op), .busy(busy)
    );

    typedef struct {
        logic [31:0] ins;
        logic        s1, s2;
        logic [31:0] r1, r2, pcv, immv, res;
        logic        jmp, ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
        return {f7, 10'd0, f3, 5'd0, op};
    endfunction

    function automatic vec_t mkv(input logic [31:0] ins, input logic s1, input logic s2,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] pcv, input logic [31:0] immv,
                                 input logic [31:0] res, input logic jmp, input logic ill);
        vec_t v;
        v.ins = ins; v.s1 = s1; v.s2 = s2; v.r1 = r1; v.r2 = r2;
        v.pcv = pcv; v.immv = immv; v.res = res; v.jmp = jmp; v.ill = ill;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        instruction = ins;
        reg1_rd     = r1;
        reg2_rd     = r2;
        alu_op1_src = 1'b0;
        alu_op2_src = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] exp, input int lat);
        int n;
        drive(ins, r1, r2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        if (lat > 1) check({name, " busy"}, 32'(busy), 32'd1);
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, lat);
        check({name, " result"}, alu_result, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = '0; reg1_rd = '0; reg2_rd = '0; pc = '0; imm = '0;
        alu_op1_src = 1'b0; alu_op2_src = 1'b0;
        repeat (2) tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", alu_result, 32'd0);
        check("reset jump", 32'(jump_flag), 32'd0);
        check("reset illegal", 32'(illegal_op), 32'd0);
        rst = 1'b0;
        tick();

        vecs.push_back(mkv(mk(OPI, 3'b000, 7'd0), 0, 1, 32'd5, 32'd0, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b000, 7'd0), 0, 0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 32'h80000000, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b000, 7'h20), 0, 0, 32'd3, 32'd5, 32'd0, 32'd0, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b010, 7'd0), 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd1, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b011, 7'd0), 0, 0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b101, 7'h20), 0, 0, 32'h80000000, 32'h24, 32'd0, 32'd0, 32'hF8000000, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b101, 7'd0), 0, 0, 32'h80000000, 32'h24, 32'd0, 32'd0, 32'h08000000, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b001, 7'd0), 0, 0, 32'd1, 32'd31, 32'd0, 32'd0, 32'h80000000, 0, 0));
        vecs.push_back(mkv(mk(OP, 3'b100, 7'd0), 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 32'd0, 32'hFF00FF00, 0, 0));
        vecs.push_back(mkv(mk(BR, 3'b100, 7'd0), 1, 1, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 32'h120, 1, 0));
        vecs.push_back(mkv(mk(BR, 3'b110, 7'd0), 1, 1, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 32'h120, 0, 0));
        vecs.push_back(mkv(mk(BR, 3'b000, 7'd0), 1, 1, 32'd7, 32'd7, 32'h100, 32'h20, 32'h120, 1, 0));
        vecs.push_back(mkv(mk(BR, 3'b001, 7'd0), 1, 1, 32'd7, 32'd7, 32'h100, 32'h20, 32'h120, 0, 0));
        vecs.push_back(mkv(mk(BR, 3'b101, 7'd0), 1, 1, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 32'h120, 0, 0));
        vecs.push_back(mkv(mk(BR, 3'b111, 7'd0), 1, 1, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 32'h120, 1, 0));
        vecs.push_back(mkv(mk(JAL, 3'b000, 7'd0), 1, 1, 32'd0, 32'd0, 32'h200, 32'h40, 32'h204, 1, 0));
        vecs.push_back(mkv(mk(LUI, 3'b000, 7'd0), 0, 1, 32'd9, 32'd0, 32'd0, 32'h12345000, 32'h12345000, 0, 0));
        vecs.push_back(mkv(mk(AUIPC, 3'b000, 7'd0), 1, 1, 32'd0, 32'd0, 32'h1000, 32'h2000, 32'h3000, 0, 0));
        vecs.push_back(mkv(mk(7'h7F, 3'b000, 7'd0), 0, 0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 0, 1));
        vecs.push_back(mkv(mk(BR, 3'b010, 7'd0), 0, 0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 0, 1));
        vecs.push_back(mkv(mk(OP, 3'b000, 7'h02), 0, 0, 32'd1, 32'd2, 32'd0, 32'd0, 32'd0, 0, 1));
        vecs.push_back(mkv(mk(OPI, 3'b001, 7'h20), 0, 1, 32'd1, 32'd0, 32'd0, 32'h401, 32'd0, 0, 1));
        vecs.push_back(mkv(mk(OPI, 3'b101, 7'h20), 0, 1, 32'h80000000, 32'd0, 32'd0, 32'h404, 32'hF8000000, 0, 0));

        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            instruction = vecs[i].ins;
            alu_op1_src = vecs[i].s1;
            alu_op2_src = vecs[i].s2;
            reg1_rd     = vecs[i].r1;
            reg2_rd     = vecs[i].r2;
            pc          = vecs[i].pcv;
            imm         = vecs[i].immv;
            in_valid    = 1'b1;
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d result", i), alu_result, vecs[i].res);
            check($sformatf("vec%0d jump", i), 32'(jump_flag), 32'(vecs[i].jmp));
            check($sformatf("vec%0d illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
        end
        in_valid = 1'b0;
        tick();
        check("idle after table", 32'(out_valid), 32'd0);

        run_op("MULHU", mk(OP, 3'b011, MD), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT + 1);
        run_op("MULH", mk(OP, 3'b001, MD), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, MUL_LAT + 1);
        run_op("MUL", mk(OP, 3'b000, MD), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, MUL_LAT + 1);
        run_op("MULHSU", mk(OP, 3'b010, MD), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT + 1);
        run_op("MUL neg", mk(OP, 3'b000, MD), 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT + 1);
        run_op("DIV -7/2", mk(OP, 3'b100, MD), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, XLEN + 1);
        run_op("REM -7/2", mk(OP, 3'b110, MD), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, XLEN + 1);
        run_op("DIV 7/-2", mk(OP, 3'b100, MD), 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, XLEN + 1);
        run_op("REM 7/-2", mk(OP, 3'b110, MD), 32'd7, 32'hFFFFFFFE, 32'd1, XLEN + 1);
        run_op("DIVU 100/7", mk(OP, 3'b101, MD), 32'd100, 32'd7, 32'd14, XLEN + 1);
        run_op("REMU 100/7", mk(OP, 3'b111, MD), 32'd100, 32'd7, 32'd2, XLEN + 1);
        run_op("DIVU max/1", mk(OP, 3'b101, MD), 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, XLEN + 1);
        run_op("DIVU 10/0", mk(OP, 3'b101, MD), 32'd10, 32'd0, 32'hFFFFFFFF, 1);
        run_op("REMU 10/0", mk(OP, 3'b111, MD), 32'd10, 32'd0, 32'd10, 1);
        run_op("DIV min/-1", mk(OP, 3'b100, MD), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM min/-1", mk(OP, 3'b110, MD), 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

        // Stall in S_DONE, then drain back-to-back
        drive(mk(OP, 3'b000, 7'd0), 32'd2, 32'd3);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        drive(mk(OP, 3'b000, 7'd0), 32'd10, 32'd20);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stall%0d result", i), alu_result, 32'd5);
            check($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        tick();
        check("b2b first valid", 32'(out_valid), 32'd1);
        check("b2b first result", alu_result, 32'd30);
        drive(mk(OP, 3'b000, 7'd0), 32'd1, 32'd1);
        tick();
        check("b2b second valid", 32'(out_valid), 32'd1);
        check("b2b second result", alu_result, 32'd2);
        in_valid = 1'b0;
        tick();
        check("b2b drained", 32'(out_valid), 32'd0);

        // Flush mid-divide; an instruction offered in the flush cycle is refused
        drive(mk(OP, 3'b101, MD), 32'd100, 32'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("pre-flush busy", 32'(busy), 32'd1);
        flush = 1'b1;
        drive(mk(OP, 3'b000, 7'd0), 32'd4, 32'd4);
        in_valid = 1'b1;
        #1;
        check("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("post-flush busy", 32'(busy), 32'd0);
        check("post-flush out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check("no output after flush", seen, 0);
        run_op("DIVU after flush", mk(OP, 3'b101, MD), 32'd100, 32'd7, 32'd14, XLEN + 1);

        // Asynchronous reset mid-divide
        drive(mk(OP, 3'b100, MD), 32'd1000, 32'd3);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset result", alu_result, 32'd0);
        tick();
        rst = 1'b0;
        run_op("DIV after reset", mk(OP, 3'b100, MD), 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, XLEN + 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
